// File: rtl/axi_bootrom_responder.sv
// rtl/axi_bootrom_responder.sv - AXI4 subordinate serving the Boot ROM region
//
// Reads are served one beat at a time from an external synchronous ROM.
// Writes are drained and answered with SLVERR.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   ar_*                       read address channel (id, addr, len, size, burst)
//   r_*                        read data channel (id, data, resp, last)
//   aw_valid_i/aw_ready_o/id   write address channel
//   w_valid_i/w_ready_o/last   write data channel (data is discarded)
//   b_*                        write response channel (always SLVERR)
//   rom_req_o/rom_addr_o       ROM read strobe and word index
//   rom_rdata_i                ROM word, valid the cycle after rom_req_o
module axi_bootrom_responder #(
  parameter int unsigned             AxiAddrWidth = 64,
  parameter int unsigned             AxiDataWidth = 64,
  parameter int unsigned             AxiIdWidth   = 4,
  parameter logic [AxiAddrWidth-1:0] RomBase      = 'h1_0000,
  parameter logic [AxiAddrWidth-1:0] RomBytes     = 'h1_0000,
  localparam int unsigned            BeatShift    = $clog2(AxiDataWidth / 8),
  localparam int unsigned            RomAddrWidth = $clog2(RomBytes) - BeatShift
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  input  logic [AxiIdWidth-1:0]   ar_id_i,
  input  logic [AxiAddrWidth-1:0] ar_addr_i,
  input  logic [7:0]              ar_len_i,
  input  logic [2:0]              ar_size_i,
  input  logic [1:0]              ar_burst_i,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [AxiIdWidth-1:0]   r_id_o,
  output logic [AxiDataWidth-1:0] r_data_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_last_o,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [AxiIdWidth-1:0]   aw_id_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  input  logic                    w_last_i,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  output logic [AxiIdWidth-1:0]   b_id_o,
  output logic [1:0]              b_resp_o,
  output logic                    rom_req_o,
  output logic [RomAddrWidth-1:0] rom_addr_o,
  input  logic [AxiDataWidth-1:0] rom_rdata_i
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [AxiAddrWidth-1:0] AddrOne  = 1;
  localparam logic [AxiAddrWidth-1:0] RomLimit = RomBase + RomBytes;

  // R_CAPTURE is the cycle in which the ROM word requested in R_FETCH is
  // on rom_rdata_i; it is registered into r_data_o on the way into R_DATA.
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_CAPTURE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  r_state_e                r_state;
  w_state_e                w_state;
  logic [AxiIdWidth-1:0]   id_q;
  logic [AxiAddrWidth-1:0] addr_q;
  logic [7:0]              len_q;
  logic [7:0]              cnt_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic [1:0]              beat_resp_q;

  logic [AxiAddrWidth-1:0] incr, span, next_addr, fetch_addr;
  logic [2:0]              fetch_size;
  logic                    wrap_ok, fetch_size_ok, fetch_in_range, fetch_hit;
  logic [1:0]              fetch_resp;
  logic [RomAddrWidth-1:0] fetch_idx;

  // Address of the beat about to be fetched: the AR address when leaving
  // idle, otherwise the successor of the current beat address.
  always_comb begin
    incr      = AddrOne << size_q;
    span      = (AxiAddrWidth'(len_q) + AddrOne) << size_q;
    wrap_ok   = (len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15);
    next_addr = (addr_q & ~(incr - AddrOne)) + incr;
    if (burst_q == BurstFixed) begin
      next_addr = addr_q;
    end else if ((burst_q == BurstWrap) && wrap_ok) begin
      next_addr = (addr_q & ~(span - AddrOne)) | ((addr_q + incr) & (span - AddrOne));
    end
    fetch_addr     = (r_state == R_IDLE) ? ar_addr_i : next_addr;
    fetch_size     = (r_state == R_IDLE) ? ar_size_i : size_q;
    fetch_size_ok  = (fetch_size <= 3'd3);
    fetch_in_range = (fetch_addr >= RomBase) && (fetch_addr < RomLimit);
    fetch_hit      = fetch_size_ok && fetch_in_range;
    fetch_resp     = !fetch_size_ok ? RespSlverr : (fetch_in_range ? RespOkay : RespDecerr);
    fetch_idx      = RomAddrWidth'((fetch_addr - RomBase) >> BeatShift);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= R_IDLE;
      ar_ready_o  <= 1'b0;
      r_valid_o   <= 1'b0;
      r_id_o      <= '0;
      r_data_o    <= '0;
      r_resp_o    <= '0;
      r_last_o    <= 1'b0;
      rom_req_o   <= 1'b0;
      rom_addr_o  <= '0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      beat_resp_q <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          ar_ready_o <= 1'b1;
          if (ar_valid_i && ar_ready_o) begin
            ar_ready_o  <= 1'b0;
            id_q        <= ar_id_i;
            addr_q      <= ar_addr_i;
            len_q       <= ar_len_i;
            size_q      <= ar_size_i;
            burst_q     <= ar_burst_i;
            cnt_q       <= '0;
            rom_req_o   <= fetch_hit;
            rom_addr_o  <= fetch_idx;
            beat_resp_q <= fetch_resp;
            r_state     <= R_FETCH;
          end
        end
        R_FETCH: begin
          rom_req_o <= 1'b0;
          r_state   <= R_CAPTURE;
        end
        R_CAPTURE: begin
          r_valid_o <= 1'b1;
          r_id_o    <= id_q;
          r_data_o  <= (beat_resp_q == RespOkay) ? rom_rdata_i : '0;
          r_resp_o  <= beat_resp_q;
          r_last_o  <= (cnt_q == len_q);
          r_state   <= R_DATA;
        end
        R_DATA: begin
          if (r_ready_i) begin
            r_valid_o <= 1'b0;
            if (r_last_o) begin
              ar_ready_o <= 1'b1;
              r_state    <= R_IDLE;
            end else begin
              addr_q      <= next_addr;
              cnt_q       <= cnt_q + 8'd1;
              rom_req_o   <= fetch_hit;
              rom_addr_o  <= fetch_idx;
              beat_resp_q <= fetch_resp;
              r_state     <= R_FETCH;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign b_resp_o = RespSlverr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state    <= W_IDLE;
      aw_ready_o <= 1'b0;
      w_ready_o  <= 1'b0;
      b_valid_o  <= 1'b0;
      b_id_o     <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          aw_ready_o <= 1'b1;
          if (aw_valid_i && aw_ready_o) begin
            aw_ready_o <= 1'b0;
            w_ready_o  <= 1'b1;
            b_id_o     <= aw_id_i;
            w_state    <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_valid_i && w_ready_o && w_last_i) begin
            w_ready_o <= 1'b0;
            b_valid_o <= 1'b1;
            w_state   <= W_RESP;
          end
        end
        W_RESP: begin
          if (b_ready_i) begin
            b_valid_o  <= 1'b0;
            aw_ready_o <= 1'b1;
            w_state    <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_bootrom_responder.sv
// tb/tb_axi_bootrom_responder.sv - scoreboard bench for axi_bootrom_responder
module tb_axi_bootrom_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ar_valid, ar_ready_o;
  logic [3:0]  ar_id;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid_o, r_ready;
  logic [3:0]  r_id_o;
  logic [63:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;
  logic        aw_valid, aw_ready_o;
  logic [3:0]  aw_id;
  logic        w_valid, w_ready_o, w_last;
  logic        b_valid_o, b_ready;
  logic [3:0]  b_id_o;
  logic [1:0]  b_resp_o;
  logic        rom_req_o;
  logic [12:0] rom_addr_o;
  logic [63:0] rom_rdata;

  axi_bootrom_responder dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id), .ar_addr_i(ar_addr),
    .ar_len_i(ar_len), .ar_size_i(ar_size), .ar_burst_i(ar_burst),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready), .r_id_o(r_id_o), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id),
    .w_valid_i(w_valid), .w_ready_o(w_ready_o), .w_last_i(w_last),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_rdata_i(rom_rdata)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] INCR = 2'b01, WRAP = 2'b10, FIXED = 2'b00;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  rbeat_t      r_exp_q[$];
  int          rom_exp_q[$];
  logic [3:0]  b_exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          r_pops = 0;
  int          w_accepts = 0;

  function automatic logic [63:0] rom_word(input int idx);
    return {16'hB007, 16'(idx), 16'hC0DE, ~16'(idx)};
  endfunction

  always @(posedge clk) if (rom_req_o) rom_rdata <= rom_word(int'(rom_addr_o));

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s", name);
  endtask

  task automatic exp_ok(input logic [3:0] id, input int idx, input logic last);
    r_exp_q.push_back('{id: id, data: rom_word(idx), resp: OKAY, last: last});
    rom_exp_q.push_back(idx);
  endtask

  task automatic exp_err(input logic [3:0] id, input logic [1:0] resp, input logic last);
    r_exp_q.push_back('{id: id, data: 64'h0, resp: resp, last: last});
  endtask

  // Monitor: pops on a handshake, checks against the queue head while stalled.
  always @(negedge clk) begin
    rbeat_t act;
    if (rst_n) begin
      act = '{id: r_id_o, data: r_data_o, resp: r_resp_o, last: r_last_o};
      if (r_valid_o) begin
        if (r_exp_q.size() == 0) fail_now("r_unexpected_beat");
        else if (r_ready) begin
          check("r_beat", 96'(act), 96'(r_exp_q.pop_front()));
          r_pops++;
        end else check("r_stall_hold", 96'(act), 96'(r_exp_q[0]));
      end
      if (rom_req_o) begin
        if (rom_exp_q.size() == 0) fail_now("rom_unexpected_req");
        else check("rom_addr", 96'(rom_addr_o), 96'(rom_exp_q.pop_front()));
      end
      if (b_valid_o) begin
        if (b_exp_q.size() == 0) fail_now("b_unexpected");
        else if (b_ready) check("b_resp", 96'({b_id_o, b_resp_o}), 96'({b_exp_q.pop_front(), SLVERR}));
        else check("b_stall_hold", 96'({b_id_o, b_resp_o}), 96'({b_exp_q[0], SLVERR}));
      end
      if (w_valid && w_ready_o) w_accepts++;
    end
  end

  task automatic send_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int lat);
    int n;
    @(posedge clk); #1;
    ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
    n = 0;
    do begin @(negedge clk); n++; end while (!ar_ready_o && n < 20);
    if (!ar_ready_o) fail_now("ar_handshake_timeout");
    @(posedge clk); #1;
    ar_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (r_valid_o) begin lat = k - 1; break; end
    end
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((r_exp_q.size() != 0 || rom_exp_q.size() != 0 || b_exp_q.size() != 0) && k < 500) begin
      @(negedge clk); k++;
    end
    if (k >= 500) begin
      fail_now(name);
      r_exp_q.delete(); rom_exp_q.delete(); b_exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_sig(input string name, input int which);
    int k;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      if ((which == 0 && aw_ready_o) || (which == 1 && w_ready_o) || (which == 2 && b_valid_o)) break;
      k++;
    end
    if (k >= 50) fail_now(name);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, wbase, k;
    rst_n = 1'b0; ar_valid = 1'b0; ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0;
    ar_burst = '0; r_ready = 1'b1; aw_valid = 1'b0; aw_id = '0; w_valid = 1'b0;
    w_last = 1'b0; b_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_ready_valid", 96'({ar_ready_o, aw_ready_o, w_ready_o, r_valid_o, b_valid_o, rom_req_o}), 96'(0));
    check("rst_r_payload", 96'({r_data_o, r_resp_o, r_id_o, r_last_o}), 96'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_readies", 96'({ar_ready_o, aw_ready_o, w_ready_o}), 96'(3'b110));

    // W before AW must not be accepted.
    @(posedge clk); #1 w_valid = 1'b1; w_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("w_before_aw_ready", 96'(w_ready_o), 96'(0));
    end
    check("w_before_aw_accepts", 96'(w_accepts), 96'(0));
    @(posedge clk); #1 w_valid = 1'b0; w_last = 1'b0;

    // 1: INCR burst of 4 words from the base.
    for (int i = 0; i < 4; i++) exp_ok(4'd2, i, i == 3);
    send_ar(4'd2, 64'h1_0000, 8'd3, 3'd3, INCR, lat);
    check("t1_latency", 96'(lat), 96'(2));
    wait_drain("t1_drain");

    // 2: WRAP of 4 starting at word 3.
    exp_ok(4'd9, 3, 1'b0); exp_ok(4'd9, 0, 1'b0); exp_ok(4'd9, 1, 1'b0); exp_ok(4'd9, 2, 1'b1);
    send_ar(4'd9, 64'h1_0018, 8'd3, 3'd3, WRAP, lat);
    wait_drain("t2_drain");

    // 3: last ROM word then past the top of the region.
    exp_ok(4'd3, 8191, 1'b0); exp_err(4'd3, DECERR, 1'b1);
    send_ar(4'd3, 64'h1_FFF8, 8'd1, 3'd3, INCR, lat);
    wait_drain("t3_drain");

    // Just below the base, FIXED out of range, and an illegal size.
    exp_err(4'd1, DECERR, 1'b1);
    send_ar(4'd1, 64'h0_FFF8, 8'd0, 3'd3, INCR, lat);
    wait_drain("below_base_drain");
    exp_err(4'd4, DECERR, 1'b0); exp_err(4'd4, DECERR, 1'b1);
    send_ar(4'd4, 64'h8, 8'd1, 3'd3, FIXED, lat);
    wait_drain("fixed_oob_drain");
    exp_err(4'd6, SLVERR, 1'b1);
    send_ar(4'd6, 64'h1_0000, 8'd0, 3'd4, INCR, lat);
    wait_drain("bad_size_drain");

    // 4: write drained, B held while b_ready is low.
    wbase = w_accepts;
    b_ready = 1'b0;
    b_exp_q.push_back(4'd5);
    @(posedge clk); #1 aw_valid = 1'b1; aw_id = 4'd5;
    wait_sig("t4_aw_timeout", 0);
    @(posedge clk); #1 aw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_valid = 1'b1; w_last = (i == 3);
      wait_sig("t4_w_timeout", 1);
      @(posedge clk); #1;
    end
    w_valid = 1'b0; w_last = 1'b0;
    wait_sig("t4_b_timeout", 2);
    for (int i = 0; i < 3; i++) begin
      check("t4_b_valid_held", 96'(b_valid_o), 96'(1));
      @(negedge clk);
    end
    @(posedge clk); #1 b_ready = 1'b1;
    wait_drain("t4_drain");
    check("t4_w_accepts", 96'(w_accepts - wbase), 96'(4));

    // 5: AR and AW together, narrow INCR read with r_ready toggling.
    wbase = w_accepts;
    exp_ok(4'd7, 8, 1'b0); exp_ok(4'd7, 8, 1'b0); exp_ok(4'd7, 9, 1'b1);
    b_exp_q.push_back(4'd6);
    @(posedge clk); #1;
    ar_valid = 1'b1; ar_id = 4'd7; ar_addr = 64'h1_0040; ar_len = 8'd2; ar_size = 3'd2; ar_burst = INCR;
    aw_valid = 1'b1; aw_id = 4'd6; w_valid = 1'b1; w_last = 1'b1;
    @(negedge clk);
    check("t5_both_ready", 96'({ar_ready_o, aw_ready_o}), 96'(2'b11));
    @(posedge clk); #1 ar_valid = 1'b0; aw_valid = 1'b0;
    wait_sig("t5_w_timeout", 1);
    @(posedge clk); #1 w_valid = 1'b0; w_last = 1'b0; r_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1 r_ready = ~r_ready;
    end
    r_ready = 1'b1;
    wait_drain("t5_drain");
    check("t5_w_accepts", 96'(w_accepts - wbase), 96'(1));

    // 6: reset in the middle of an 8-beat burst.
    wbase = r_pops;
    for (int i = 0; i < 8; i++) exp_ok(4'd10, i, i == 7);
    send_ar(4'd10, 64'h1_0000, 8'd7, 3'd3, INCR, lat);
    check("t6_latency", 96'(lat), 96'(2));
    k = 0;
    while (r_pops - wbase < 2 && k < 100) begin @(negedge clk); k++; end
    while (!r_valid_o && k < 100) begin @(negedge clk); k++; end
    if (k >= 100) fail_now("t6_wait_timeout");
    #1 rst_n = 1'b0;
    #1;
    check("t6_reset_immediate", 96'({r_valid_o, rom_req_o, ar_ready_o}), 96'(0));
    r_exp_q.delete(); rom_exp_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_after_release", 96'({ar_ready_o, r_valid_o}), 96'(2'b10));
    exp_ok(4'd11, 1, 1'b1);
    send_ar(4'd11, 64'h1_0008, 8'd0, 3'd3, INCR, lat);
    wait_drain("t6_post_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
